// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-write handshake bundle for the write-port arbiter.
// master = requesters plus FIFO status, slave = arbiter.
interface fifo_wr_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 8
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*DWIDTH-1:0] req_data;
    logic [NREQ-1:0]        req_last;
    logic [NREQ-1:0]        req_ready;
    logic                   wfull;
    logic                   winc;
    logic [DWIDTH-1:0]      wdata;

    modport master (
        output req_valid, req_data, req_last, wfull,
        input  req_ready, winc, wdata
    );

    modport slave (
        input  req_valid, req_data, req_last, wfull,
        output req_ready, winc, wdata
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ requesters,
// granting bursts of up to BURST_MAX words with wfull backpressure.
//
// state | meaning
// IDLE  | no owner; pick next valid requester after last-served, grant next edge
// BURST | grant held; words move on !wfull, ends on last/BURST_MAX/withdraw
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DWIDTH    = 8,
    parameter int BURST_MAX = 4
) (
    input  logic             wclk,
    input  logic             wrst,
    fifo_wr_arbiter_if.slave bus,
    output logic [NREQ-1:0]  grant,
    output logic             busy
);
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW   = $clog2(BURST_MAX + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state;
    logic [IDXW-1:0] last_idx;
    logic [BW-1:0]   beat_cnt;
    logic [IDXW-1:0] g_idx;
    logic [IDXW-1:0] sel_idx;
    logic            any_valid;
    logic            active;
    logic            xfer;
    logic            burst_end;
    int              cand;

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) g_idx = IDXW'(i);
        end
    end

    // Scan starts just after the last-served requester, so whoever was served
    // most recently has the lowest priority next time.
    always_comb begin
        sel_idx   = '0;
        any_valid = 1'b0;
        cand      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_idx) + k) % NREQ;
            if (!any_valid && bus.req_valid[IDXW'(cand)]) begin
                any_valid = 1'b1;
                sel_idx   = IDXW'(cand);
            end
        end
    end

    // A word offered during the reset cycle must not reach the FIFO.
    assign active    = (state == BURST) && !wrst;
    assign xfer      = active && bus.req_valid[g_idx] && !bus.wfull;
    assign burst_end = (xfer && (bus.req_last[g_idx] || beat_cnt == BW'(BURST_MAX - 1)))
                     || (active && !bus.wfull && !bus.req_valid[g_idx]);

    assign bus.winc      = xfer;
    assign bus.req_ready = (active && !bus.wfull) ? grant : '0;
    assign bus.wdata     = (grant != '0) ? bus.req_data[g_idx*DWIDTH +: DWIDTH] : '0;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state    <= IDLE;
            grant    <= '0;
            busy     <= 1'b0;
            beat_cnt <= '0;
            last_idx <= IDXW'(NREQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant    <= {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
                        beat_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (xfer) beat_cnt <= beat_cnt + 1'b1;
                    if (burst_end) begin
                        grant    <= '0;
                        busy     <= 1'b0;
                        last_idx <= g_idx;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic checked
// against a cycle-level reference model and per-requester word-order scoreboard.
module tb_fifo_wr_arbiter;
    localparam int NREQ      = 4;
    localparam int DWIDTH    = 8;
    localparam int BURST_MAX = 4;

    logic            wclk = 1'b0;
    logic            wrst;
    logic [NREQ-1:0] grant;
    logic            busy;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .DWIDTH(DWIDTH)) bus ();

    fifo_wr_arbiter #(.NREQ(NREQ), .DWIDTH(DWIDTH), .BURST_MAX(BURST_MAX)) dut (
        .wclk  (wclk),
        .wrst  (wrst),
        .bus   (bus.slave),
        .grant (grant),
        .busy  (busy)
    );

    always #5 wclk = ~wclk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // requester drivers
    bit   [NREQ-1:0]   v, l, nl, acc, prev_v;
    int                rem [NREQ];
    logic [DWIDTH-1:0] d   [NREQ];
    logic [DWIDTH-1:0] q   [NREQ][$];
    bit                rnd, rst_r, full_r;

    // reference model: owner index (-1 = nobody), last-served, words this burst
    int m_owner, m_last, m_beats;
    bit m_winc;

    // observations of the most recent cycle
    logic [NREQ-1:0] o_grant, o_ready, prev_grant;
    logic            o_winc, o_busy;
    int              winc_cnt, burst_len;
    int              waits [NREQ];
    int              bl_q [$];
    logic [NREQ-1:0] gq [$];

    task automatic start_pkt(input int i, input int len, input bit nolast);
        rem[i] = len;
        v[i]   = 1'b1;
        nl[i]  = nolast;
        d[i]   = DWIDTH'($urandom);
        q[i].push_back(d[i]);
    endtask

    function automatic int idx_of(input logic [NREQ-1:0] g);
        int r = -1;
        for (int i = 0; i < NREQ; i++) if (g[i]) r = i;
        return r;
    endfunction

    task automatic tick();
        logic [NREQ-1:0] m_grant, m_ready;
        int gi;
        @(negedge wclk);
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
                acc[i] = 1'b0;
                rem[i]--;
                if (rem[i] > 0) begin
                    d[i] = DWIDTH'($urandom);
                    q[i].push_back(d[i]);
                end else begin
                    v[i] = 1'b0;
                end
            end
            if (rnd && !v[i] && $urandom_range(0, 99) < 30)
                start_pkt(i, $urandom_range(1, 6), $urandom_range(0, 3) == 0);
            l[i] = v[i] && !nl[i] && rem[i] == 1;
        end
        if (rnd) begin
            full_r = ($urandom_range(0, 99) < 25);
            rst_r  = ($urandom_range(0, 499) == 0);
        end
        wrst          = rst_r;
        bus.wfull     = full_r;
        bus.req_valid = v;
        bus.req_last  = l;
        for (int i = 0; i < NREQ; i++) bus.req_data[i*DWIDTH +: DWIDTH] = d[i];
        #1;
        m_grant = '0;
        m_ready = '0;
        m_winc  = 1'b0;
        if (m_owner >= 0) begin
            m_grant[m_owner] = 1'b1;
            if (!rst_r && !full_r) begin
                m_ready = m_grant;
                m_winc  = v[m_owner];
            end
        end
        chk_val("grant", 32'(grant), 32'(m_grant));
        chk_val("busy", 32'(busy), 32'(m_owner >= 0));
        chk_val("winc", 32'(bus.winc), 32'(m_winc));
        chk_val("req_ready", 32'(bus.req_ready), 32'(m_ready));
        if (m_winc) chk_val("wdata", 32'(bus.wdata), 32'(d[m_owner]));
        if (m_owner < 0) chk_val("wdata_idle", 32'(bus.wdata), 32'd0);
        chk_val("winc_while_full", 32'(bus.winc & full_r), 32'd0);
        chk_val("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
        if (bus.winc) begin
            gi = idx_of(grant);
            if (gi < 0 || q[gi].size() == 0) chk_val("sb_owner", 32'd0, 32'd1);
            else chk_val("sb_order", 32'(bus.wdata), 32'(q[gi].pop_front()));
        end
        if (prev_grant == '0 && grant != '0) begin
            gi = idx_of(grant);
            gq.push_back(grant);
            for (int i = 0; i < NREQ; i++) begin
                if (i == gi) waits[i] = 0;
                else if (prev_v[i]) begin
                    waits[i]++;
                    chk_val("starve", 32'(waits[i] <= NREQ - 1), 32'd1);
                end
            end
        end
        for (int i = 0; i < NREQ; i++) if (!v[i] || rst_r) waits[i] = 0;
        if (prev_grant != '0 && grant == '0) begin
            bl_q.push_back(burst_len);
            burst_len = 0;
        end
        if (bus.winc) begin
            burst_len++;
            winc_cnt++;
        end
        o_grant = grant;
        o_ready = bus.req_ready;
        o_winc  = bus.winc;
        o_busy  = busy;
        for (int i = 0; i < NREQ; i++) acc[i] = m_ready[i] & v[i];
        prev_grant = grant;
        prev_v     = v;
        @(posedge wclk);
        if (rst_r) begin
            m_owner = -1;
            m_last  = NREQ - 1;
            m_beats = 0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= NREQ; k++)
                if (m_owner < 0 && v[(m_last + k) % NREQ]) m_owner = (m_last + k) % NREQ;
            m_beats = 0;
        end else begin
            if (m_winc) m_beats++;
            if ((m_winc && (l[m_owner] || m_beats == BURST_MAX)) || (!full_r && !v[m_owner])) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end
    endtask

    task automatic quiesce();
        v = '0; l = '0; nl = '0; acc = '0;
        full_r = 1'b0;
        rnd    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = 0;
            q[i].delete();
        end
        rst_r = 1'b1;
        tick();
        rst_r = 1'b0;
        bl_q.delete();
        gq.delete();
        burst_len = 0;
        winc_cnt  = 0;
    endtask

    logic [NREQ-1:0] exp_ord [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        wrst = 1'b1;
        bus.wfull = 1'b0; bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0;
        m_owner = -1; m_last = NREQ - 1; m_beats = 0;
        prev_grant = '0; prev_v = '0;
        for (int i = 0; i < NREQ; i++) begin waits[i] = 0; d[i] = '0; end
        repeat (2) @(posedge wclk);

        // reset state
        quiesce();
        tick();
        chk_val("rst_grant", 32'(o_grant), 32'd0);
        chk_val("rst_busy", 32'(o_busy), 32'd0);

        // single 3-word packet on requester 0
        start_pkt(0, 3, 1'b0);
        tick();
        chk_val("t1_arb_cycle", 32'(o_grant), 32'd0);
        tick();
        chk_val("t1_grant", 32'(o_grant), 32'b0001);
        repeat (3) tick();
        chk_val("t1_words", 32'(winc_cnt), 32'd3);
        chk_val("t1_release", 32'(o_grant), 32'd0);
        chk_val("t1_busy", 32'(o_busy), 32'd0);

        // all requesters continuous, never last: round robin, BURST_MAX each
        quiesce();
        for (int i = 0; i < NREQ; i++) start_pkt(i, 1000, 1'b1);
        repeat (26) tick();
        for (int k = 0; k < 5; k++)
            chk_val("t2_order", (gq.size() > k) ? 32'(gq[k]) : 32'hdead, 32'(exp_ord[k]));
        for (int k = 0; k < 4; k++)
            chk_val("t2_burst_len", (bl_q.size() > k) ? 32'(bl_q[k]) : 32'hdead, 32'(BURST_MAX));

        // stall on wfull after 2nd word of requester 2
        quiesce();
        start_pkt(2, 4, 1'b0);
        repeat (3) tick();
        chk_val("t3_pre_stall", 32'(winc_cnt), 32'd2);
        full_r = 1'b1;
        repeat (5) begin
            tick();
            chk_val("t3_stall_winc", 32'(o_winc), 32'd0);
            chk_val("t3_stall_ready", 32'(o_ready), 32'd0);
            chk_val("t3_stall_grant", 32'(o_grant), 32'b0100);
        end
        full_r = 1'b0;
        repeat (3) tick();
        chk_val("t3_words", 32'(winc_cnt), 32'd4);
        chk_val("t3_release", 32'(o_grant), 32'd0);

        // requester 1 withdraws after one word; next scan starts at 2
        quiesce();
        start_pkt(1, 1, 1'b1);
        repeat (3) tick();
        tick();
        chk_val("t4_withdraw", 32'(o_grant), 32'd0);
        start_pkt(0, 1, 1'b0);
        start_pkt(2, 1, 1'b0);
        start_pkt(3, 1, 1'b0);
        repeat (2) tick();
        chk_val("t4_next", 32'(o_grant), 32'b0100);

        // reset during 3rd word
        quiesce();
        start_pkt(3, 6, 1'b0);
        repeat (3) tick();
        rst_r = 1'b1;
        start_pkt(0, 2, 1'b0);
        tick();
        chk_val("t5_rst_winc", 32'(o_winc), 32'd0);
        chk_val("t5_words", 32'(winc_cnt), 32'd2);
        rst_r = 1'b0;
        tick();
        chk_val("t5_idle", 32'(o_grant), 32'd0);
        tick();
        chk_val("t5_first", 32'(o_grant), 32'b0001);

        // random traffic
        quiesce();
        rnd = 1'b1;
        repeat (10000) tick();
        rnd   = 1'b0;
        rst_r = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the async FIFO write side among NREQ requesters.
- Grants one requester at a time for a burst of up to BURST_MAX words. Drives winc/wdata into the FIFO write logic and applies backpressure from wfull.
- Sits entirely in the wclk domain, directly in front of the FIFO write-pointer/full logic.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DWIDTH, 8, data word width
- BURST_MAX, 4, maximum words per grant (1..15)

Ports:
- wclk  in  1  write-domain clock, all logic on rising edge
- wrst  in  1  synchronous reset, active-high
- req_valid  in  NREQ  per-requester word valid
- req_data  in  NREQ*DWIDTH  requester i data in bits [i*DWIDTH +: DWIDTH]
- req_last  in  NREQ  marks final word of requester's packet
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- wfull  in  1  FIFO full flag (registered, wclk domain)
- winc  out  1  FIFO write enable
- wdata  out  DWIDTH  FIFO write data
- grant  out  NREQ  registered one-hot current owner, 0 when idle
- busy  out  1  high in BURST state

Behaviour:
- Reset: at a wclk edge with wrst=1:
  - state=IDLE, grant=0, busy=0, beat count=0.
  - Last-served pointer=NREQ-1, so requester 0 has first priority.
  - Combinational outputs winc=0 and req_ready=0 follow while in reset and IDLE.
  - wdata value is don't-care when winc=0; implement as 0 when grant=0.
- State IDLE:
  - If any req_valid, select the first set bit scanning from (last+1) mod NREQ upward with wrap.
  - Next edge: grant<=one-hot(sel), beat count<=0, state<=BURST.
  - Arbitration latency is one cycle. No transfer occurs in IDLE.
- State BURST, with g = granted index:
  - req_ready[g] = ~wfull; all other req_ready bits are 0.
  - winc = req_valid[g] & ~wfull.
  - wdata = req_data slice g (combinational mux on registered grant).
  - A transfer is a cycle with winc=1; beat count increments on each transfer.
- Burst ends (next edge: state<=IDLE, grant<=0, last<=g) on any of:
  - a transfer with req_last[g]=1;
  - a transfer that makes beat count equal to BURST_MAX;
  - req_valid[g]=0 while wfull=0 (requester withdrew).
- wfull=1 in BURST:
  - Stall: winc=0, req_ready=0, beat count and grant held.
  - No release on valid drop while full; no timeout.
  - The burst resumes the cycle wfull falls.
- Requesters must hold req_valid/req_data stable until accepted. A requester whose valid is set while another holds the grant waits; it is never starved, serviced within (NREQ-1) bursts.
- Minimum one idle cycle between consecutive bursts (IDLE arbitration cycle).
- Beat count width is clog2(BURST_MAX+1); never exceeds BURST_MAX.
- Reset mid-burst: the in-progress burst is abandoned; the next cycle is IDLE with pointer restored to NREQ-1. A word presented in the reset cycle is not written (winc=0).
- Invariants:
  - winc never asserted while wfull=1 or grant=0.
  - popcount(grant)≤1 and popcount(req_ready)≤1.

Test Plan:
- Reset, then req_valid=4'b0001, 3 words, last on 3rd, wfull=0 -> grant=0001 one cycle after valid; winc high 3 consecutive cycles with wdata matching; then grant=0, busy=0.
- All four requesters valid continuously, never last, BURST_MAX=4 -> bursts granted in order 0,1,2,3,0; each exactly 4 winc pulses; one idle cycle between bursts.
- Requester 2 in burst, wfull=1 for 5 cycles after 2nd word -> winc=0 and req_ready=0 for those 5 cycles; grant held at 0100; remaining 2 words written after wfull falls; 4 words total.
- Requester 1 granted, drops req_valid after 1 word with wfull=0 -> burst ends, grant=0 next cycle; next arbitration starts scan at requester 2.
- wrst asserted during 3rd word of a burst -> winc=0 that cycle; state IDLE, grant=0; with requesters 0 and 3 valid, requester 0 granted first.
- Random valid/last/wfull for 10k cycles -> scoreboard: per-requester word order preserved; no winc while wfull; grant one-hot or zero; no requester waits more than (NREQ-1) bursts.
